// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the SPI serial-in/parallel-out receiver.
package sipo_rx_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int SYNC_STAGES = 2;

  // Rising SCK carries data when polarity and phase agree, falling otherwise.
  function automatic logic sample_on_rise(input logic cph, input logic cpol);
    return ~(cph ^ cpol);
  endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Pin-side and word-side signals of sipo_rx; DATA_ACK/OVERRUN exist only
// when SIPO_RX_OVERRUN_EN is defined.
interface sipo_rx_if #(parameter int D_PACK = 8);
  logic              SCK;
  logic              SER_IN;
  logic              ENABLE;
  logic              C_PH;
  logic              C_POL;
  logic [D_PACK-1:0] DATA_OUT;
  logic              DATA_VALID;
  logic              BUSY;
`ifdef SIPO_RX_OVERRUN_EN
  logic              DATA_ACK;
  logic              OVERRUN;

  modport slave  (input  SCK, SER_IN, ENABLE, C_PH, C_POL, DATA_ACK,
                  output DATA_OUT, DATA_VALID, BUSY, OVERRUN);
  modport master (output SCK, SER_IN, ENABLE, C_PH, C_POL, DATA_ACK,
                  input  DATA_OUT, DATA_VALID, BUSY, OVERRUN);
`else
  modport slave  (input  SCK, SER_IN, ENABLE, C_PH, C_POL,
                  output DATA_OUT, DATA_VALID, BUSY);
  modport master (output SCK, SER_IN, ENABLE, C_PH, C_POL,
                  input  DATA_OUT, DATA_VALID, BUSY);
`endif
endinterface

// File: rtl/sipo_rx_sync_2ff.sv
// One-bit flop-chain synchronizer for pin inputs entering the CLK domain.
module sync_2ff
  import sipo_rx_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sipo_rx.sv
// SPI receive shifter: MSB-first D_PACK-bit words from pin SCK/SER_IN/ENABLE.
// Optional SIPO_RX_OVERRUN_EN turns DATA_VALID into an acked level with OVERRUN.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int D_PACK = 8
) (
  input  logic     CLK,
  input  logic     RST,
  sipo_rx_if.slave bus
);

  localparam int              CW   = $clog2(D_PACK);
  localparam logic [CW-1:0]   LAST = CW'(D_PACK - 1);

  logic sck_s, ser_s, en_s;

  sync_2ff u_sync_sck (.CLK(CLK), .RST(RST), .d(bus.SCK),    .q(sck_s));
  sync_2ff u_sync_ser (.CLK(CLK), .RST(RST), .d(bus.SER_IN), .q(ser_s));
  sync_2ff u_sync_en  (.CLK(CLK), .RST(RST), .d(bus.ENABLE), .q(en_s));

  // Edges are registered; ser_d is delayed alongside so it matches the edge.
  logic sck_h, rise_r, fall_r, ser_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_h  <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      ser_d  <= 1'b0;
    end else begin
      sck_h  <= sck_s;
      rise_r <= sck_s & ~sck_h;
      fall_r <= ~sck_s & sck_h;
      ser_d  <= ser_s;
    end
  end

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [D_PACK-2:0] shreg, shreg_n;
  logic [D_PACK-1:0] dout, dout_n;
  logic              vld, vld_n;
  logic              on_rise, on_rise_n;
  logic              done;
  logic              smp;
  logic [D_PACK-1:0] word;
`ifdef SIPO_RX_OVERRUN_EN
  logic              ovr, ovr_n;
`endif

  assign word = {shreg, ser_d};
  assign smp  = on_rise ? rise_r : fall_r;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    dout_n    = dout;
    on_rise_n = on_rise;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        shreg_n = '0;
        if (!en_s) begin
          state_n   = SHIFT;
          on_rise_n = sample_on_rise(bus.C_PH, bus.C_POL);
        end
      end
      SHIFT: begin
        // A deselect in the same cycle as a sample edge drops the edge.
        if (en_s) begin
          state_n = IDLE;
          cnt_n   = '0;
          shreg_n = '0;
        end else if (smp) begin
          shreg_n = word[D_PACK-2:0];
          if (cnt == LAST) begin
            cnt_n  = '0;
            dout_n = word;
            done   = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SIPO_RX_OVERRUN_EN
    vld_n = done | (vld & ~bus.DATA_ACK);
    ovr_n = ovr | (done & vld & ~bus.DATA_ACK);
`else
    vld_n = done;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      dout    <= '0;
      vld     <= 1'b0;
      on_rise <= 1'b0;
`ifdef SIPO_RX_OVERRUN_EN
      ovr     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      dout    <= dout_n;
      vld     <= vld_n;
      on_rise <= on_rise_n;
`ifdef SIPO_RX_OVERRUN_EN
      ovr     <= ovr_n;
`endif
    end
  end

  assign bus.DATA_OUT   = dout;
  assign bus.DATA_VALID = vld;
  assign bus.BUSY       = |cnt;
`ifdef SIPO_RX_OVERRUN_EN
  assign bus.OVERRUN    = ovr;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: directed SPI frames in all four modes,
// abort, reset mid-word, and the SIPO_RX_OVERRUN_EN behaviour when built with it.
module tb_sipo_rx;
  localparam int DW = 8;
  localparam int HP = 4;  // SCK half period in CLK cycles

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sipo_rx_if #(.D_PACK(DW)) bus();

  sipo_rx #(.D_PACK(DW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    string         nm;
    int            sel;  // 0 DATA_OUT, 1 DATA_VALID, 2 BUSY, 3 OVERRUN, 4 words left
    logic [DW-1:0] exp;
  } probe_t;

  logic [DW-1:0] exp_q[$];
  probe_t        prb_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_en = 1'b1;
  bit            auto_ack = 1'b1;
  bit            force_ack = 1'b0;
  logic [DW-1:0] mon_exp, mon_act;
  probe_t        mon_p;

  // Monitor: pops the scoreboard on every presented word and services probes.
  initial begin
`ifdef SIPO_RX_OVERRUN_EN
    bus.DATA_ACK = 1'b0;
`endif
    forever begin
      @(negedge CLK);
      if (!RST && mon_en && bus.DATA_VALID === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL word: got %h, required no word (unexpected DATA_VALID)", bus.DATA_OUT);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.DATA_OUT !== mon_exp) begin
            n_bad++;
            $display("FAIL word: got %h, required %h", bus.DATA_OUT, mon_exp);
          end
        end
      end
      while (prb_q.size() > 0) begin
        mon_p = prb_q.pop_front();
        case (mon_p.sel)
          0:       mon_act = bus.DATA_OUT;
          1:       mon_act = DW'(bus.DATA_VALID);
          2:       mon_act = DW'(bus.BUSY);
`ifdef SIPO_RX_OVERRUN_EN
          3:       mon_act = DW'(bus.OVERRUN);
`endif
          default: mon_act = DW'(exp_q.size());
        endcase
        n_cmp++;
        if (mon_act !== mon_p.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, required %h", mon_p.nm, mon_act, mon_p.exp);
        end
      end
`ifdef SIPO_RX_OVERRUN_EN
      bus.DATA_ACK = force_ack | (auto_ack & (bus.DATA_VALID === 1'b1));
`endif
    end
  end

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timed out");
  end

  task automatic probe(input string nm, input int sel, input logic [DW-1:0] e);
    probe_t p;
    p.nm = nm; p.sel = sel; p.exp = e;
    prb_q.push_back(p);
  endtask

  task automatic set_mode(input logic cpol, input logic cph);
    bus.C_POL = cpol;
    bus.C_PH  = cph;
    bus.SCK   = cpol;
    repeat (6) @(negedge CLK);
  endtask

  task automatic start_frame();
    bus.ENABLE = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic end_frame();
    repeat (6) @(negedge CLK);
    bus.ENABLE = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  // Called at the negedge of the final sample edge; spans one SCK half period.
  task automatic latency_probe();
    repeat (3) @(posedge CLK);
    #1 probe("valid_lat3", 1, 8'h00);
    @(posedge CLK);
    #1 probe("valid_lat4", 1, 8'h01);
    @(negedge CLK);
  endtask

  task automatic send_bits(input logic [15:0] d, input int n, input bit lat);
    for (int i = n - 1; i >= 0; i--) begin
      if (!bus.C_PH) begin
        bus.SER_IN = d[i];
        repeat (HP) @(negedge CLK);
        bus.SCK = ~bus.C_POL;
        if (lat && i == 0) latency_probe();
        else repeat (HP) @(negedge CLK);
        bus.SCK = bus.C_POL;
      end else begin
        bus.SCK    = ~bus.C_POL;
        bus.SER_IN = d[i];
        repeat (HP) @(negedge CLK);
        bus.SCK = bus.C_POL;
        if (lat && i == 0) latency_probe();
        else repeat (HP) @(negedge CLK);
      end
    end
  endtask

  initial begin
    bus.SCK = 1'b0; bus.SER_IN = 1'b0; bus.ENABLE = 1'b1;
    bus.C_PH = 1'b0; bus.C_POL = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    probe("rst_data_out", 0, 8'h00);
    probe("rst_valid", 1, 8'h00);
    probe("rst_busy", 2, 8'h00);
`ifdef SIPO_RX_OVERRUN_EN
    probe("rst_overrun", 3, 8'h00);
`endif
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Mode 0 with output latency check
    set_mode(1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    start_frame();
    send_bits(16'h00A5, 8, 1'b1);
    end_frame();
    @(posedge CLK); #1 probe("mode0_data_out", 0, 8'hA5);
    @(negedge CLK);

    // Mode 3, two words back to back
    set_mode(1'b1, 1'b1);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    start_frame();
    send_bits(16'h3CC3, 16, 1'b0);
    end_frame();

    // Modes 1 and 2 sample on falling SCK
    set_mode(1'b0, 1'b1);
    exp_q.push_back(8'h81);
    start_frame();
    send_bits(16'h0081, 8, 1'b0);
    end_frame();
    set_mode(1'b1, 1'b0);
    exp_q.push_back(8'h81);
    start_frame();
    send_bits(16'h0081, 8, 1'b0);
    end_frame();

    // Abort after 5 bits, then a full word
    set_mode(1'b0, 1'b0);
    start_frame();
    send_bits(16'h0016, 5, 1'b0);
    @(posedge CLK); #1 probe("abort_busy_mid", 2, 8'h01);
    end_frame();
    @(posedge CLK); #1;
    probe("abort_busy_gap", 2, 8'h00);
    probe("abort_data_kept", 0, 8'h81);
    @(negedge CLK);
    exp_q.push_back(8'h55);
    start_frame();
    send_bits(16'h0055, 8, 1'b0);
    end_frame();

    // Reset after 3 bits of 0xFF, then 0x12
    start_frame();
    send_bits(16'h00FF, 3, 1'b0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bus.ENABLE = 1'b1;
    @(posedge CLK); #1;
    probe("reset_mid_data_out", 0, 8'h00);
    probe("reset_mid_busy", 2, 8'h00);
    repeat (6) @(negedge CLK);
    exp_q.push_back(8'h12);
    start_frame();
    send_bits(16'h0012, 8, 1'b0);
    end_frame();

`ifdef SIPO_RX_OVERRUN_EN
    mon_en   = 1'b0;
    auto_ack = 1'b0;
    start_frame();
    send_bits(16'h0011, 8, 1'b0);
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1;
    probe("ovr_first_valid", 1, 8'h01);
    probe("ovr_first_data", 0, 8'h11);
    probe("ovr_first_flag", 3, 8'h00);
    @(negedge CLK);
    send_bits(16'h0022, 8, 1'b0);
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1;
    probe("ovr_second_data", 0, 8'h22);
    probe("ovr_second_valid", 1, 8'h01);
    probe("ovr_second_flag", 3, 8'h01);
    force_ack = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    force_ack = 1'b0;
    probe("ovr_ack_valid", 1, 8'h00);
    probe("ovr_ack_flag", 3, 8'h01);
    @(negedge CLK);
    end_frame();
    auto_ack = 1'b1;
    mon_en   = 1'b1;
`endif

    @(posedge CLK); #1 probe("words_left", 4, 8'h00);
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
